// File: rtl/tank_flow_controller.sv
// tank_flow_controller: sequences the shared tank between refill and drip/sprinkler irrigation with sensor filtering.
module tank_flow_controller #(
  parameter int FILL_TIMEOUT = 500_000_000,
  parameter int ERR_FILTER = 1000
) (
  input  logic       clk,
  input  logic       init,
  input  logic       high_level_i,
  input  logic       middle_level_i,
  input  logic       low_level_i,
  input  logic [1:0] irrigation_req_i,
  input  logic       ack_i,
  output logic       inlet_valve_o,
  output logic       drip_o,
  output logic       sprinkler_o,
  output logic       error_o,
  output logic       alarm_o,
  output logic [1:0] state_o
);
  localparam int FW = $clog2(FILL_TIMEOUT + 1);
  localparam int EW = $clog2(ERR_FILTER + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, IRRIGATE = 2'b01, FILL = 2'b10, ERROR = 2'b11} state_t;
  state_t state, state_nxt;
  logic mode, mode_nxt;
  logic [FW-1:0] fill_cnt;
  logic [EW-1:0] err_cnt, err_nxt;
  logic [2:0] lvl;
  logic valid, req_act;
  assign lvl = {high_level_i, middle_level_i, low_level_i};
  assign valid = lvl == 3'b000 || lvl == 3'b001 || lvl == 3'b011 || lvl == 3'b111;
  assign req_act = irrigation_req_i == 2'b01 || irrigation_req_i == 2'b10;
  assign err_nxt = valid ? '0 : (err_cnt == EW'(ERR_FILTER)) ? err_cnt : err_cnt + EW'(1);
  always_comb begin
    state_nxt = state;
    mode_nxt = mode;
    case (state)
      IDLE: begin
        if (!low_level_i) state_nxt = FILL;
        else if (irrigation_req_i == 2'b01) begin
          state_nxt = IRRIGATE;
          mode_nxt = 1'b0;
        end else if (irrigation_req_i == 2'b10 && middle_level_i) begin
          state_nxt = IRRIGATE;
          mode_nxt = 1'b1;
        end else if (irrigation_req_i == 2'b10) state_nxt = FILL;
      end
      IRRIGATE: begin
        if (mode ? !middle_level_i : !low_level_i) state_nxt = FILL;
        else if (irrigation_req_i != (mode ? 2'b10 : 2'b01)) state_nxt = IDLE;
      end
      FILL: begin
        if (high_level_i) state_nxt = IDLE;
        else if (fill_cnt == FW'(FILL_TIMEOUT - 1)) state_nxt = ERROR;
      end
      ERROR: if (ack_i && valid && err_cnt == '0) state_nxt = IDLE;
    endcase
    // A persistent inconsistent reading overrides every other transition
    if (err_nxt == EW'(ERR_FILTER)) state_nxt = ERROR;
  end
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state <= IDLE;
      mode <= 1'b0;
      fill_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      mode <= mode_nxt;
      fill_cnt <= (state != FILL) ? '0 : (fill_cnt == FW'(FILL_TIMEOUT)) ? fill_cnt : fill_cnt + FW'(1);
      err_cnt <= err_nxt;
    end
  end
  assign inlet_valve_o = state == FILL;
  assign drip_o = state == IRRIGATE && !mode;
  assign sprinkler_o = state == IRRIGATE && mode;
  assign error_o = state == ERROR;
  assign alarm_o = state == ERROR || (state == FILL && req_act);
  assign state_o = state;
endmodule

// File: tb/tb_tank_flow_controller.sv
// tb_tank_flow_controller: table-driven and scoreboarded checks of tank_flow_controller.
module tb_tank_flow_controller;
  logic clk = 1'b0;
  logic init = 1'b1;
  logic [2:0] lvl = 3'b111;
  logic [1:0] req = 2'b00;
  logic ack = 1'b0;
  logic inlet_valve, drip, sprinkler, error, alarm;
  logic [1:0] state;
  logic [6:0] got;
  int n_vec = 0;
  int n_bad = 0;
  localparam logic [6:0] O_IDLE  = 7'b00000_00;
  localparam logic [6:0] O_FILL  = 7'b10000_10;
  localparam logic [6:0] O_FILLA = 7'b10001_10;
  localparam logic [6:0] O_DRIP  = 7'b01000_01;
  localparam logic [6:0] O_SPR   = 7'b00100_01;
  localparam logic [6:0] O_ERR   = 7'b00011_11;
  typedef struct {
    logic [2:0] lvl;
    logic [1:0] req;
    logic ack;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [6:0] sb[$];
  tank_flow_controller #(.FILL_TIMEOUT(20), .ERR_FILTER(4)) dut (
    .clk(clk),
    .init(init),
    .high_level_i(lvl[2]),
    .middle_level_i(lvl[1]),
    .low_level_i(lvl[0]),
    .irrigation_req_i(req),
    .ack_i(ack),
    .inlet_valve_o(inlet_valve),
    .drip_o(drip),
    .sprinkler_o(sprinkler),
    .error_o(error),
    .alarm_o(alarm),
    .state_o(state)
  );
  assign got = {inlet_valve, drip, sprinkler, error, alarm, state};
  always #5 clk = ~clk;
  task automatic check(input string name);
    logic [6:0] e;
    e = sb.pop_front();
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: outputs {valve,drip,spr,err,alarm,state} got %b expected %b", name, got, e);
    end
  endtask
  task automatic step(input string name, input logic [2:0] l, input logic [1:0] r, input logic a, input logic [6:0] e);
    @(negedge clk);
    lvl = l;
    req = r;
    ack = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask
  initial begin
    // refill with hysteresis
    tbl.push_back('{3'b000, 2'b00, 1'b0, O_FILL});
    for (int i = 0; i < 4; i++) tbl.push_back('{3'b001, 2'b00, 1'b0, O_FILL});
    for (int i = 0; i < 4; i++) tbl.push_back('{3'b011, 2'b00, 1'b0, O_FILL});
    tbl.push_back('{3'b111, 2'b00, 1'b0, O_IDLE});
    tbl.push_back('{3'b111, 2'b00, 1'b0, O_IDLE});
    // sprinkler gating
    tbl.push_back('{3'b001, 2'b10, 1'b0, O_FILLA});
    tbl.push_back('{3'b001, 2'b10, 1'b0, O_FILLA});
    tbl.push_back('{3'b111, 2'b10, 1'b0, O_IDLE});
    tbl.push_back('{3'b111, 2'b10, 1'b0, O_SPR});
    tbl.push_back('{3'b111, 2'b10, 1'b0, O_SPR});
    tbl.push_back('{3'b001, 2'b10, 1'b0, O_FILLA});
    tbl.push_back('{3'b111, 2'b00, 1'b0, O_IDLE});
    // mode change goes through IDLE
    tbl.push_back('{3'b011, 2'b01, 1'b0, O_DRIP});
    tbl.push_back('{3'b011, 2'b01, 1'b0, O_DRIP});
    tbl.push_back('{3'b011, 2'b10, 1'b0, O_IDLE});
    tbl.push_back('{3'b011, 2'b10, 1'b0, O_SPR});
    tbl.push_back('{3'b011, 2'b00, 1'b0, O_IDLE});
    // level drop beats request change; req 11 is none; empty beats request
    tbl.push_back('{3'b011, 2'b01, 1'b0, O_DRIP});
    tbl.push_back('{3'b000, 2'b00, 1'b0, O_FILL});
    tbl.push_back('{3'b111, 2'b11, 1'b0, O_IDLE});
    tbl.push_back('{3'b111, 2'b11, 1'b0, O_IDLE});
    tbl.push_back('{3'b000, 2'b01, 1'b0, O_FILLA});
    tbl.push_back('{3'b111, 2'b01, 1'b0, O_IDLE});
    tbl.push_back('{3'b111, 2'b01, 1'b0, O_DRIP});
    tbl.push_back('{3'b111, 2'b00, 1'b0, O_IDLE});
    tbl.push_back('{3'b111, 2'b00, 1'b1, O_IDLE});
    #2;
    sb.push_back(O_IDLE);
    check("reset");
    @(negedge clk);
    init = 1'b0;
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].req, tbl[i].ack, tbl[i].exp);
    step("to_fill", 3'b000, 2'b00, 1'b0, O_FILL);
    for (int i = 1; i < 20; i++) step($sformatf("fill%0d", i), 3'b011, 2'b00, 1'b0, O_FILL);
    step("timeout", 3'b011, 2'b00, 1'b0, O_ERR);
    step("err_hold", 3'b011, 2'b01, 1'b0, O_ERR);
    step("err_ack", 3'b011, 2'b00, 1'b1, O_IDLE);
    step("to_fill2", 3'b000, 2'b00, 1'b0, O_FILL);
    for (int i = 1; i < 20; i++) step($sformatf("fill2_%0d", i), 3'b011, 2'b00, 1'b0, O_FILL);
    step("high_on_timeout", 3'b111, 2'b00, 1'b0, O_IDLE);
    for (int i = 0; i < 3; i++) step($sformatf("filt3_%0d", i), 3'b101, 2'b00, 1'b0, O_IDLE);
    step("filt_clear", 3'b011, 2'b00, 1'b0, O_IDLE);
    for (int i = 0; i < 3; i++) step($sformatf("filt4_%0d", i), 3'b101, 2'b00, 1'b0, O_IDLE);
    step("filt_err", 3'b101, 2'b00, 1'b0, O_ERR);
    step("ack_invalid", 3'b101, 2'b00, 1'b1, O_ERR);
    step("ack_cnt_nonzero", 3'b011, 2'b00, 1'b1, O_ERR);
    step("ack_ok", 3'b011, 2'b00, 1'b1, O_IDLE);
    step("pre_reset_fill", 3'b000, 2'b00, 1'b0, O_FILL);
    #2;
    init = 1'b1;
    sb.push_back(O_IDLE);
    #1;
    check("async_reset");
    init = 1'b0;
    step("resume", 3'b111, 2'b01, 1'b0, O_DRIP);
    step("resume_idle", 3'b111, 2'b00, 1'b0, O_IDLE);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
